reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 16, meaning cycles held in reset after synchronised release; legal range 1..65535.
REQ-002 The module SHALL have parameter STAGES, default 3, meaning number of sequentially released reset domains; legal range 1..8.
REQ-003 The module SHALL have parameter TIMEOUT, default 1024, meaning max wait cycles per stage acknowledge; legal range 1..65535, used only with the timeout feature.
REQ-004 Port clk  input  1  the single clock; all sequential logic SHALL use its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port stage_rst  output  STAGES  per-stage reset, active-high; bit k drives domain k.
REQ-007 Port stage_ack  input  STAGES  bit k high means domain k has finished initialising; level, not pulse.
REQ-008 Port ready  output  1  high once every stage is released and acknowledged.
REQ-009 Port timeout_err  output  STAGES  sticky flag; bit k set when stage k's acknowledge timed out.

Function
REQ-010 States SHALL be SYNC, HOLD, WAIT(k) for k=0..STAGES-1, and DONE.
REQ-011 Release of rst SHALL pass through a 2-flop synchroniser; SYNC SHALL exit to HOLD on the 2nd rising edge at which rst is sampled low.
REQ-012 HOLD SHALL count exactly HOLD_CYCLES edges. The counter width SHALL be ceil(log2(HOLD_CYCLES+1)), with no wrap.
REQ-013 stage_rst[0] SHALL fall, and WAIT(0) SHALL be entered, exactly 2+HOLD_CYCLES rising edges after the first edge with rst low.
REQ-014 In WAIT(k), stage_ack[k] sampled high at an edge SHALL advance the machine on that edge:
- if k<STAGES-1, stage_rst[k+1] falls and WAIT(k+1) is entered;
- otherwise ready rises and DONE is entered.
REQ-015 stage_ack[k] SHALL be ignored while stage_rst[k] is high and after stage k has been accepted; an already-high ack SHALL be accepted on the first WAIT(k) edge, so stages then release on consecutive edges.
REQ-016 Released stages SHALL stay released. stage_rst bits SHALL only fall, in index order, until the next reset.
REQ-017 DONE SHALL be terminal. ready SHALL remain 1 regardless of stage_ack until rst.
REQ-018 stage_rst, ready and timeout_err SHALL be registered outputs, with no combinational path from stage_ack.

Reset
REQ-019 While rst is high: stage_rst=all ones, ready=0, timeout_err=0, state=SYNC, counters=0, synchroniser=asserted.
REQ-020 Assertion of rst SHALL take effect asynchronously, without a clock edge, in any state including mid-WAIT and DONE.
REQ-021 After rst, the full sequence SHALL restart from SYNC; prior timeout_err SHALL be cleared.
REQ-022 An rst glitch shorter than one clock period SHALL still force a complete restart, including the HOLD period.

Configuration
REQ-023 Macro RESET_SEQ_TIMEOUT_EN SHALL enable the per-stage timeout.
REQ-024 With RESET_SEQ_TIMEOUT_EN defined:
- a wait counter SHALL clear on entry to each WAIT(k);
- if TIMEOUT edges elapse in WAIT(k) without ack, timeout_err[k] SHALL set and the machine SHALL advance exactly as if acked;
- an ack arriving on the same edge as the timeout SHALL count as ack, with no error.
REQ-025 Without RESET_SEQ_TIMEOUT_EN:
- WAIT(k) SHALL wait indefinitely;
- timeout_err SHALL be constant 0;
- no wait counter SHALL be synthesised.

Verification
REQ-026 Defaults, rst high 5 cycles then low, stage_ack=3'b111 tied -> stage_rst[0] falls on edge 18, stage_rst[1] on edge 19, stage_rst[2] on edge 20, ready on edge 21.
REQ-027 Defaults, ack[0] raised 40 cycles after stage_rst[0] falls -> stage_rst[1] falls on that ack's sampling edge; stage_rst[2] stays 1.
REQ-028 rst pulsed mid-WAIT(1) -> stage_rst=3'b111 and ready=0 immediately (asynchronously); the sequence repeats with full 18-edge delay.
REQ-029 RESET_SEQ_TIMEOUT_EN defined, ack[1] never raised -> timeout_err=3'b010 exactly 1024 edges after WAIT(1) entry; stage_rst[2] falls on the same edge; ready follows ack[2].
REQ-030 RESET_SEQ_TIMEOUT_EN defined, ack[0] raised on edge 1024 of WAIT(0) -> timeout_err[0] stays 0.
REQ-031 In DONE, drop all stage_ack -> ready stays 1 and stage_rst stays 3'b000.

Source files
------------

// File: rtl/reset_seq.sv
// Purpose : reset sequencer; synchronises release of rst, holds for HOLD_CYCLES,
//           then releases STAGES reset domains one at a time on each domain's ack.
// Latency : stage_rst[0] falls 2+HOLD_CYCLES edges after rst is first sampled low;
//           each later stage falls on the edge its predecessor's ack is sampled.
// Backpr. : a stage waits for its own ack (level); with RESET_SEQ_TIMEOUT_EN
//           defined, the wait is bounded by TIMEOUT edges and sets timeout_err[k].
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous active-high reset
//   stage_rst    out  STAGES  per-domain reset, active-high, released in index order
//   stage_ack    in   STAGES  per-domain "initialised" level
//   ready        out  1       all domains released and acknowledged
//   timeout_err  out  STAGES  sticky per-stage ack timeout flag
// Optional feature macro: RESET_SEQ_TIMEOUT_EN (per-stage ack timeout).
module reset_seq #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic [STAGES-1:0] stage_rst,
    input  logic [STAGES-1:0] stage_ack,
    output logic              ready,
    output logic [STAGES-1:0] timeout_err
);

    // Elaboration-time parameter range checks.
    if (HOLD_CYCLES == 0 || HOLD_CYCLES > 65535) begin : g_chk_hold
        $error("reset_seq: HOLD_CYCLES out of range 1..65535");
    end
    if (STAGES == 0 || STAGES > 8) begin : g_chk_stages
        $error("reset_seq: STAGES out of range 1..8");
    end
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_chk_timeout
        $error("reset_seq: TIMEOUT out of range 1..65535");
    end

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);

    // Gray-coded so every legal transition flips a single state bit; the
    // SYNC->HOLD step is driven by the first synchroniser flop, making the
    // state register the second synchroniser stage.
    typedef enum logic [1:0] {
        ST_SYNC = 2'b00,
        ST_HOLD = 2'b01,
        ST_WAIT = 2'b11,
        ST_DONE = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_meta;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [STAGES-1:0]   r_stage_rst;
    logic                r_ready;

    logic                w_ack;
    logic                w_advance;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_ack     = stage_ack[r_idx];
    assign w_idx_nxt = r_idx + 1'b1;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0]     r_wait_cnt;
    logic [STAGES-1:0]   r_timeout_err;
    logic                w_timeout;

    assign w_timeout   = (r_wait_cnt == TO_LAST);
    // Ack wins over a timeout landing on the same edge.
    assign w_advance   = w_ack || w_timeout;
    assign timeout_err = r_timeout_err;
`else
    assign w_advance   = w_ack;
    assign timeout_err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_SYNC;
            r_meta        <= 1'b1;
            r_hold_cnt    <= '0;
            r_idx         <= '0;
            r_stage_rst   <= '1;
            r_ready       <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= '0;
`endif
        end else begin
            r_meta <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    if (!r_meta) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Exit on the HOLD_CYCLES-th edge spent in HOLD.
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state        <= ST_WAIT;
                        r_stage_rst[0] <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_advance) begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        r_wait_cnt <= '0;
                        if (!w_ack) begin
                            r_timeout_err[r_idx] <= 1'b1;
                        end
`endif
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_stage_rst[w_idx_nxt] <= 1'b0;
                            r_idx                  <= w_idx_nxt;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    // Terminal until the next rst.
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    assign stage_rst = r_stage_rst;
    assign ready     = r_ready;

endmodule

// File: tb/tb_reset_seq.sv
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] stage_ack = 3'b000;
    logic [2:0] stage_rst;
    logic       ready;
    logic [2:0] timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reset_seq dut (
        .clk         (clk),
        .rst         (rst),
        .stage_rst   (stage_rst),
        .stage_ack   (stage_ack),
        .ready       (ready),
        .timeout_err (timeout_err)
    );

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold rst for n edges; the next rising edge after return is edge 1.
    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        stage_ack = 3'b000;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (stage_rst !== 3'b111) begin n_fail++; $display("FAIL reset_stage_rst got=%b exp=111", stage_rst); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++; if (timeout_err !== 3'b000) begin n_fail++; $display("FAIL reset_timeout_err got=%b exp=000", timeout_err); end
        tick(3);
        n_checks++; if (stage_rst !== 3'b111 || ready !== 1'b0) begin n_fail++; $display("FAIL reset_held got=%b/%b exp=111/0", stage_rst, ready); end
    endtask

    task automatic test_tied_ack;
        stage_ack = 3'b111;
        apply_reset(5);
        tick(17);
        n_checks++; if (stage_rst !== 3'b111) begin n_fail++; $display("FAIL tied_edge17 got=%b exp=111", stage_rst); end
        tick(1);
        n_checks++; if (stage_rst !== 3'b110) begin n_fail++; $display("FAIL tied_edge18 got=%b exp=110", stage_rst); end
        tick(1);
        n_checks++; if (stage_rst !== 3'b100) begin n_fail++; $display("FAIL tied_edge19 got=%b exp=100", stage_rst); end
        tick(1);
        n_checks++; if (stage_rst !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL tied_edge20 got=%b/%b exp=000/0", stage_rst, ready); end
        tick(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL tied_edge21_ready got=%b exp=1", ready); end
    endtask

    task automatic test_done_ignores_ack;
        @(negedge clk);
        stage_ack = 3'b000;
        tick(4);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL done_ready got=%b exp=1", ready); end
        n_checks++; if (stage_rst !== 3'b000) begin n_fail++; $display("FAIL done_stage_rst got=%b exp=000", stage_rst); end
        n_checks++; if (timeout_err !== 3'b000) begin n_fail++; $display("FAIL done_timeout_err got=%b exp=000", timeout_err); end
    endtask

    task automatic test_rst_in_done;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (stage_rst !== 3'b111 || ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_done got=%b/%b exp=111/0", stage_rst, ready); end
    endtask

    task automatic test_slow_ack;
        stage_ack = 3'b000;
        apply_reset(3);
        tick(18);
        n_checks++; if (stage_rst !== 3'b110) begin n_fail++; $display("FAIL slow_edge18 got=%b exp=110", stage_rst); end
        tick(39);
        n_checks++; if (stage_rst !== 3'b110) begin n_fail++; $display("FAIL slow_edge57 got=%b exp=110", stage_rst); end
        @(negedge clk);
        stage_ack = 3'b001;
        tick(1);
        n_checks++; if (stage_rst !== 3'b100) begin n_fail++; $display("FAIL slow_edge58 got=%b exp=100", stage_rst); end
        tick(6);
        n_checks++; if (stage_rst !== 3'b100 || ready !== 1'b0) begin n_fail++; $display("FAIL slow_stage2_held got=%b/%b exp=100/0", stage_rst, ready); end
    endtask

    // Sub-period rst pulse while in WAIT(1): must restart including HOLD.
    task automatic test_glitch_mid_wait;
        @(negedge clk);
        stage_ack = 3'b111;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (stage_rst !== 3'b111 || ready !== 1'b0) begin n_fail++; $display("FAIL glitch_async got=%b/%b exp=111/0", stage_rst, ready); end
        #1 rst = 1'b0;
        tick(17);
        n_checks++; if (stage_rst !== 3'b111) begin n_fail++; $display("FAIL glitch_edge17 got=%b exp=111", stage_rst); end
        tick(1);
        n_checks++; if (stage_rst !== 3'b110) begin n_fail++; $display("FAIL glitch_edge18 got=%b exp=110", stage_rst); end
        tick(3);
        n_checks++; if (stage_rst !== 3'b000 || ready !== 1'b1) begin n_fail++; $display("FAIL glitch_edge21 got=%b/%b exp=000/1", stage_rst, ready); end
    endtask

    // ack[1] withheld: bounded wait with the timeout feature, unbounded without.
    task automatic test_ack_stall;
        stage_ack = 3'b001;
        apply_reset(2);
        tick(19);
        n_checks++; if (stage_rst !== 3'b100) begin n_fail++; $display("FAIL stall_edge19 got=%b exp=100", stage_rst); end
        tick(1023);
        n_checks++; if (stage_rst !== 3'b100 || timeout_err !== 3'b000) begin n_fail++; $display("FAIL stall_edge1042 got=%b/%b exp=100/000", stage_rst, timeout_err); end
        tick(1);
`ifdef RESET_SEQ_TIMEOUT_EN
        n_checks++; if (timeout_err !== 3'b010) begin n_fail++; $display("FAIL stall_timeout_err got=%b exp=010", timeout_err); end
        n_checks++; if (stage_rst !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL stall_timeout_adv got=%b/%b exp=000/0", stage_rst, ready); end
        tick(3);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL stall_wait2_ready got=%b exp=0", ready); end
        @(negedge clk);
        stage_ack = 3'b100;
        tick(1);
        n_checks++; if (ready !== 1'b1 || timeout_err !== 3'b010) begin n_fail++; $display("FAIL stall_ready got=%b/%b exp=1/010", ready, timeout_err); end
`else
        n_checks++; if (stage_rst !== 3'b100 || timeout_err !== 3'b000) begin n_fail++; $display("FAIL stall_no_timeout got=%b/%b exp=100/000", stage_rst, timeout_err); end
        tick(200);
        n_checks++; if (stage_rst !== 3'b100 || ready !== 1'b0) begin n_fail++; $display("FAIL stall_still_waiting got=%b/%b exp=100/0", stage_rst, ready); end
        @(negedge clk);
        stage_ack = 3'b011;
        tick(1);
        n_checks++; if (stage_rst !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL stall_late_ack got=%b/%b exp=000/0", stage_rst, ready); end
        @(negedge clk);
        stage_ack = 3'b111;
        tick(1);
        n_checks++; if (ready !== 1'b1 || timeout_err !== 3'b000) begin n_fail++; $display("FAIL stall_ready got=%b/%b exp=1/000", ready, timeout_err); end
`endif
    endtask

    // ack[0] first sampled on the 1024th edge of WAIT(0): accepted, no error.
    task automatic test_ack_on_timeout_edge;
        stage_ack = 3'b000;
        apply_reset(2);
        tick(18);
        n_checks++; if (stage_rst !== 3'b110) begin n_fail++; $display("FAIL tedge_edge18 got=%b exp=110", stage_rst); end
        tick(1023);
        n_checks++; if (stage_rst !== 3'b110 || timeout_err !== 3'b000) begin n_fail++; $display("FAIL tedge_edge1041 got=%b/%b exp=110/000", stage_rst, timeout_err); end
        @(negedge clk);
        stage_ack = 3'b001;
        tick(1);
        n_checks++; if (stage_rst !== 3'b100) begin n_fail++; $display("FAIL tedge_adv got=%b exp=100", stage_rst); end
        n_checks++; if (timeout_err !== 3'b000) begin n_fail++; $display("FAIL tedge_err got=%b exp=000", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_tied_ack();
        test_done_ignores_ack();
        test_rst_in_done();
        test_slow_ack();
        test_glitch_mid_wait();
        test_ack_stall();
        test_ack_on_timeout_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
